mem_sram_bridge: RTL and testbench

MEM_SRAM_BRIDGE -- requirements
Module: mem_sram_bridge

---
 rtl/mem_bridge_pkg.sv | 22 ++
 rtl/mem_sram_bridge_if.sv | 31 +++
 rtl/mem_sram_bridge.sv | 156 +++++++++++++++
 tb/tb_mem_sram_bridge.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the memory-to-SRAM bridge: one-hot state encodings
// and a ceiling-log2 helper used to size the read-latency counter.
package mem_bridge_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'b0001,
      S_ISSUE   = 4'b0010,
      S_RD_WAIT = 4'b0100,
      S_ACK     = 4'b1000
   } bridge_state_t;

   // ceil(log2(v)); returns 0 for v <= 1
   function automatic int log2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_sram_bridge_if.sv
// Upstream request/response and single-port SRAM signals of the bridge.
// slave = bridge side, master = requester plus SRAM side.
interface mem_sram_bridge_if #(
   parameter int MEM_DATA_WIDTH  = 64,
   parameter int MEM_ADDR_WIDTH  = 32,
   parameter int SRAM_ADDR_WIDTH = 10
);
   logic                       mem_req_vld;
   logic                       mem_wr_en;
   logic                       mem_rd_en;
   logic [MEM_ADDR_WIDTH-1:0]  mem_addr;
   logic [MEM_DATA_WIDTH-1:0]  mem_wr_data;
   logic                       mem_ack_vld;
   logic                       mem_err;
   logic [MEM_DATA_WIDTH-1:0]  mem_rd_data;
   logic                       sram_cs;
   logic                       sram_we;
   logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
   logic [MEM_DATA_WIDTH-1:0]  sram_wdata;
   logic [MEM_DATA_WIDTH-1:0]  sram_rdata;

   modport slave (
      input  mem_req_vld, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data, sram_rdata,
      output mem_ack_vld, mem_err, mem_rd_data, sram_cs, sram_we, sram_addr, sram_wdata
   );

   modport master (
      output mem_req_vld, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data, sram_rdata,
      input  mem_ack_vld, mem_err, mem_rd_data, sram_cs, sram_we, sram_addr, sram_wdata
   );
endinterface

// File: rtl/mem_sram_bridge.sv
// Bridges a level-held upstream word request onto a single-port SRAM with a
// fixed read latency; one request in flight, every output registered.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  S_IDLE    | waiting for mem_req_vld; request latched and classified here
//  S_ISSUE   | one-cycle SRAM access (cs high)
//  S_RD_WAIT | RD_LATENCY cycles for read data; captured on the last one
//  S_ACK     | one-cycle ack (err for illegal requests, data for reads)
module mem_sram_bridge
   import mem_bridge_pkg::*;
#(
   parameter int MEM_DATA_WIDTH  = 64,
   parameter int MEM_ADDR_WIDTH  = 32,
   parameter int SRAM_ADDR_WIDTH = 10,
   parameter int RD_LATENCY      = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              soft_rst,
   mem_sram_bridge_if.slave  bus
);

   localparam int                CNT_W    = log2(RD_LATENCY) + 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LATENCY - 1);

   bridge_state_t              state_q, state_d;
   logic                       wr_q, wr_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       ack_q, ack_d;
   logic                       err_q, err_d;
   logic [MEM_DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                       cs_q, cs_d;
   logic                       we_q, we_d;
   logic [SRAM_ADDR_WIDTH-1:0] saddr_q, saddr_d;
   logic [MEM_DATA_WIDTH-1:0]  swdata_q, swdata_d;

   logic addr_hi_nz;
   logic req_illegal;

   generate
      if (SRAM_ADDR_WIDTH < MEM_ADDR_WIDTH) begin : g_addr_hi
         assign addr_hi_nz = |bus.mem_addr[MEM_ADDR_WIDTH-1:SRAM_ADDR_WIDTH];
      end else begin : g_no_addr_hi
         assign addr_hi_nz = 1'b0;
      end
   endgenerate

   assign req_illegal = addr_hi_nz | (bus.mem_wr_en == bus.mem_rd_en);

   // The latched address/data live directly in the SRAM output registers:
   // they are only needed during S_ISSUE, and must read 0 everywhere else.
   always_comb begin
      state_d  = state_q;
      wr_d     = wr_q;
      cnt_d    = cnt_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      rdata_d  = '0;
      cs_d     = 1'b0;
      we_d     = 1'b0;
      saddr_d  = '0;
      swdata_d = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.mem_req_vld) begin
               wr_d = bus.mem_wr_en;
               if (req_illegal) begin
                  state_d = S_ACK;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d  = S_ISSUE;
                  cs_d     = 1'b1;
                  we_d     = bus.mem_wr_en;
                  saddr_d  = bus.mem_addr[SRAM_ADDR_WIDTH-1:0];
                  swdata_d = bus.mem_wr_en ? bus.mem_wr_data : '0;
               end
            end
         end
         S_ISSUE: begin
            if (wr_q) begin
               state_d = S_ACK;
               ack_d   = 1'b1;
            end else begin
               state_d = S_RD_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         S_RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_ACK;
               ack_d   = 1'b1;
               rdata_d = bus.sram_rdata;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (soft_rst) begin
         state_d  = S_IDLE;
         wr_d     = 1'b0;
         cnt_d    = '0;
         ack_d    = 1'b0;
         err_d    = 1'b0;
         rdata_d  = '0;
         cs_d     = 1'b0;
         we_d     = 1'b0;
         saddr_d  = '0;
         swdata_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_q     <= 1'b0;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         cs_q     <= 1'b0;
         we_q     <= 1'b0;
         saddr_q  <= '0;
         swdata_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         cs_q     <= cs_d;
         we_q     <= we_d;
         saddr_q  <= saddr_d;
         swdata_q <= swdata_d;
      end
   end

   assign bus.mem_ack_vld = ack_q;
   assign bus.mem_err     = err_q;
   assign bus.mem_rd_data = rdata_q;
   assign bus.sram_cs     = cs_q;
   assign bus.sram_we     = we_q;
   assign bus.sram_addr   = saddr_q;
   assign bus.sram_wdata  = swdata_q;

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Bench for mem_sram_bridge: two instances (RD_LATENCY 3 and 4) with SRAM
// models; acks are checked against a scoreboard of expected responses.
module tb_mem_sram_bridge;

   localparam int DW = 64;
   localparam int AW = 32;
   localparam int SW = 10;
   localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;

   typedef struct {
      logic        err;
      logic [63:0] rdata;
      int          ack_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic soft_rst3 = 1'b0;
   logic soft_rst4 = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_sram_bridge_if #(.MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .SRAM_ADDR_WIDTH(SW)) ifc3 ();
   mem_sram_bridge_if #(.MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .SRAM_ADDR_WIDTH(SW)) ifc4 ();

   mem_sram_bridge #(.MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .SRAM_ADDR_WIDTH(SW),
                     .RD_LATENCY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst3), .bus(ifc3.slave));

   mem_sram_bridge #(.MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .SRAM_ADDR_WIDTH(SW),
                     .RD_LATENCY(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst4), .bus(ifc4.slave));

   // SRAM models: read data appears RD_LATENCY cycles after the access, for one cycle only
   logic [63:0] mem3 [0:1023];
   logic [63:0] pipe3 [0:2];
   logic [63:0] mem4 [0:1023];
   logic [63:0] pipe4 [0:3];

   always @(posedge clk) begin
      if (ifc3.sram_cs && ifc3.sram_we) mem3[ifc3.sram_addr] <= ifc3.sram_wdata;
      pipe3[0] <= (ifc3.sram_cs && !ifc3.sram_we) ? mem3[ifc3.sram_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
      for (int i = 1; i < 3; i++) pipe3[i] <= pipe3[i-1];
      if (ifc4.sram_cs && ifc4.sram_we) mem4[ifc4.sram_addr] <= ifc4.sram_wdata;
      pipe4[0] <= (ifc4.sram_cs && !ifc4.sram_we) ? mem4[ifc4.sram_addr] : 64'hBAD1_BAD1_BAD1_BAD1;
      for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
   end

   assign ifc3.sram_rdata = pipe3[2];
   assign ifc4.sram_rdata = pipe4[3];

   // monitor for the RD_LATENCY=3 instance
   int          wr_cnt3 = 0;
   int          rd_cnt3 = 0;
   int          cs_cyc3 = -1;
   logic        last_we3 = 1'b0;
   logic [9:0]  last_addr3 = '0;
   logic [63:0] last_wdata3 = '0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (ifc3.sram_cs) begin
               if (ifc3.sram_we) wr_cnt3++; else rd_cnt3++;
               cs_cyc3     = cyc;
               last_we3    = ifc3.sram_we;
               last_addr3  = ifc3.sram_addr;
               last_wdata3 = ifc3.sram_wdata;
               total++;
               if (ifc3.mem_ack_vld !== 1'b0) begin
                  bad++;
                  $display("FAIL cs_in_ack cyc=%0d got ack=%b want 0", cyc, ifc3.mem_ack_vld);
               end
            end else begin
               total++;
               if ({ifc3.sram_we, ifc3.sram_addr, ifc3.sram_wdata} !== '0) begin
                  bad++;
                  $display("FAIL sram_idle cyc=%0d got we=%b addr=%h wdata=%h want 0",
                           cyc, ifc3.sram_we, ifc3.sram_addr, ifc3.sram_wdata);
               end
            end
            if (ifc3.mem_ack_vld === 1'b1) begin
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_ack cyc=%0d got ack with empty scoreboard", cyc);
               end else begin
                  e = sb.pop_front();
                  if (ifc3.mem_err !== e.err) begin
                     bad++;
                     $display("FAIL ack_err cyc=%0d got %b want %b", cyc, ifc3.mem_err, e.err);
                  end
                  total++;
                  if (ifc3.mem_rd_data !== e.rdata) begin
                     bad++;
                     $display("FAIL ack_rdata cyc=%0d got %h want %h", cyc, ifc3.mem_rd_data, e.rdata);
                  end
                  total++;
                  if (cyc !== e.ack_cyc) begin
                     bad++;
                     $display("FAIL ack_cycle got %0d want %0d", cyc, e.ack_cyc);
                  end
               end
            end else begin
               total++;
               if (ifc3.mem_err !== 1'b0 || ifc3.mem_rd_data !== '0) begin
                  bad++;
                  $display("FAIL out_idle cyc=%0d got err=%b rdata=%h want 0",
                           cyc, ifc3.mem_err, ifc3.mem_rd_data);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic req3(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [63:0] data, input logic exp_err,
                       input logic [63:0] exp_rd, input int lat, output int c0);
      exp_t e;
      int   n;
      @(negedge clk);
      ifc3.mem_req_vld = 1'b1;
      ifc3.mem_wr_en   = wr;
      ifc3.mem_rd_en   = rd;
      ifc3.mem_addr    = addr;
      ifc3.mem_wr_data = data;
      c0 = cyc;
      e.err = exp_err;
      e.rdata = exp_rd;
      e.ack_cyc = c0 + lat;
      sb.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ifc3.mem_ack_vld !== 1'b1 && n < 20);
      if (ifc3.mem_ack_vld !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL ack_timeout addr=%h got no ack within 20 cycles", addr);
         sb.delete();
      end
      // request stays high through the ack cycle and drops in the following one
      @(posedge clk);
      #1;
      ifc3.mem_req_vld = 1'b0;
      ifc3.mem_wr_en   = 1'b0;
      ifc3.mem_rd_en   = 1'b0;
      ifc3.mem_addr    = '0;
      ifc3.mem_wr_data = '0;
   endtask

   task automatic run4(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [63:0] data, output int lat, output logic [63:0] rdat);
      int c0;
      int n;
      @(negedge clk);
      ifc4.mem_req_vld = 1'b1;
      ifc4.mem_wr_en   = wr;
      ifc4.mem_rd_en   = rd;
      ifc4.mem_addr    = addr;
      ifc4.mem_wr_data = data;
      c0 = cyc;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ifc4.mem_ack_vld !== 1'b1 && n < 20);
      lat  = (ifc4.mem_ack_vld === 1'b1) ? cyc - c0 : -1;
      rdat = ifc4.mem_rd_data;
      @(posedge clk);
      #1;
      ifc4.mem_req_vld = 1'b0;
      ifc4.mem_wr_en   = 1'b0;
      ifc4.mem_rd_en   = 1'b0;
      ifc4.mem_addr    = '0;
      ifc4.mem_wr_data = '0;
   endtask

   task automatic test_reset();
      ifc3.mem_req_vld = 1'b0; ifc3.mem_wr_en = 1'b0; ifc3.mem_rd_en = 1'b0;
      ifc3.mem_addr = '0; ifc3.mem_wr_data = '0;
      ifc4.mem_req_vld = 1'b0; ifc4.mem_wr_en = 1'b0; ifc4.mem_rd_en = 1'b0;
      ifc4.mem_addr = '0; ifc4.mem_wr_data = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({ifc3.mem_ack_vld, ifc3.mem_err, ifc3.mem_rd_data, ifc3.sram_cs, ifc3.sram_we,
           ifc3.sram_addr, ifc3.sram_wdata} !== '0) begin
         bad++;
         $display("FAIL reset_out3 got ack=%b err=%b cs=%b want all 0",
                  ifc3.mem_ack_vld, ifc3.mem_err, ifc3.sram_cs);
      end
      total++;
      if ({ifc4.mem_ack_vld, ifc4.mem_err, ifc4.mem_rd_data, ifc4.sram_cs, ifc4.sram_we,
           ifc4.sram_addr, ifc4.sram_wdata} !== '0) begin
         bad++;
         $display("FAIL reset_out4 got ack=%b err=%b cs=%b want all 0",
                  ifc4.mem_ack_vld, ifc4.mem_err, ifc4.sram_cs);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      ifc3.mem_req_vld = 1'b1; ifc3.mem_wr_en = 1'b1; ifc3.mem_addr = 32'h2A;
      ifc3.mem_wr_data = 64'h5555_AAAA_5555_AAAA;
      @(posedge clk);
      #2;
      total++;
      if (ifc3.sram_cs !== 1'b1 || ifc3.sram_addr !== 10'h2A) begin
         bad++;
         $display("FAIL async_pre_issue got cs=%b addr=%h want 1 02a", ifc3.sram_cs, ifc3.sram_addr);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({ifc3.sram_cs, ifc3.sram_we, ifc3.sram_addr, ifc3.sram_wdata} !== '0) begin
         bad++;
         $display("FAIL async_clear got cs=%b we=%b addr=%h want 0",
                  ifc3.sram_cs, ifc3.sram_we, ifc3.sram_addr);
      end
      ifc3.mem_req_vld = 1'b0; ifc3.mem_wr_en = 1'b0; ifc3.mem_addr = '0; ifc3.mem_wr_data = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_write();
      int c0;
      int wc;
      wc = wr_cnt3;
      req3(1'b1, 1'b0, 32'h5, D0, 1'b0, '0, 2, c0);
      total++;
      if (cs_cyc3 !== c0 + 1 || last_we3 !== 1'b1 || last_addr3 !== 10'h5 || last_wdata3 !== D0) begin
         bad++;
         $display("FAIL write_issue got cyc=%0d we=%b addr=%h wdata=%h want cyc=%0d we=1 addr=005 wdata=%h",
                  cs_cyc3, last_we3, last_addr3, last_wdata3, c0 + 1, D0);
      end
      total++;
      if (wr_cnt3 !== wc + 1) begin
         bad++;
         $display("FAIL write_count got %0d want %0d", wr_cnt3, wc + 1);
      end
   endtask

   task automatic test_read();
      int          c0;
      int          rc;
      logic [63:0] v;
      rc = rd_cnt3;
      req3(1'b0, 1'b1, 32'h5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, D0, 5, c0);
      total++;
      if (cs_cyc3 !== c0 + 1 || last_we3 !== 1'b0 || last_addr3 !== 10'h5 || last_wdata3 !== '0) begin
         bad++;
         $display("FAIL read_issue got cyc=%0d we=%b addr=%h wdata=%h want cyc=%0d we=0 addr=005 wdata=0",
                  cs_cyc3, last_we3, last_addr3, last_wdata3, c0 + 1);
      end
      total++;
      if (rd_cnt3 !== rc + 1) begin
         bad++;
         $display("FAIL read_count got %0d want %0d", rd_cnt3, rc + 1);
      end
      // top legal address
      v = {$urandom, $urandom};
      req3(1'b1, 1'b0, 32'h3FF, v, 1'b0, '0, 2, c0);
      req3(1'b0, 1'b1, 32'h3FF, '0, 1'b0, v, 5, c0);
   endtask

   task automatic test_illegal_addr();
      int c0;
      int n0;
      n0 = wr_cnt3 + rd_cnt3;
      req3(1'b0, 1'b1, 32'h400, '0, 1'b1, '0, 1, c0);
      req3(1'b1, 1'b0, 32'h8000_0005, 64'h1, 1'b1, '0, 1, c0);
      total++;
      if (wr_cnt3 + rd_cnt3 !== n0) begin
         bad++;
         $display("FAIL illegal_addr_access got %0d accesses want %0d", wr_cnt3 + rd_cnt3, n0);
      end
   endtask

   task automatic test_illegal_both();
      int          c0;
      int          n0;
      logic [63:0] v;
      v = {$urandom, $urandom};
      req3(1'b1, 1'b0, 32'h3, v, 1'b0, '0, 2, c0);
      n0 = wr_cnt3 + rd_cnt3;
      req3(1'b1, 1'b1, 32'h3, ~v, 1'b1, '0, 1, c0);
      req3(1'b0, 1'b0, 32'h3, ~v, 1'b1, '0, 1, c0);
      total++;
      if (wr_cnt3 + rd_cnt3 !== n0) begin
         bad++;
         $display("FAIL illegal_both_access got %0d accesses want %0d", wr_cnt3 + rd_cnt3, n0);
      end
      req3(1'b0, 1'b1, 32'h3, '0, 1'b0, v, 5, c0);
   endtask

   task automatic test_back_to_back();
      int          c0;
      int          wc;
      int          rc;
      logic [63:0] vals [4];
      wc = wr_cnt3;
      rc = rd_cnt3;
      for (int i = 0; i < 4; i++) begin
         vals[i] = {$urandom, $urandom};
         req3(1'b1, 1'b0, 32'h10 + i, vals[i], 1'b0, '0, 2, c0);
      end
      total++;
      if (wr_cnt3 !== wc + 4 || rd_cnt3 !== rc) begin
         bad++;
         $display("FAIL b2b_write_count got wr=%0d rd=%0d want wr=%0d rd=%0d",
                  wr_cnt3, rd_cnt3, wc + 4, rc);
      end
      for (int i = 0; i < 4; i++) begin
         req3(1'b0, 1'b1, 32'h10 + i, '0, 1'b0, vals[i], 5, c0);
      end
      total++;
      if (rd_cnt3 !== rc + 4) begin
         bad++;
         $display("FAIL b2b_read_count got %0d want %0d", rd_cnt3, rc + 4);
      end
      repeat (2) @(negedge clk);
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL sb_drained got %0d pending want 0", sb.size());
      end
   endtask

   task automatic test_soft_rst();
      int          c0;
      int          lat;
      logic [63:0] rdat;
      logic [63:0] w;
      logic        saw_ack;
      w = {$urandom, $urandom};
      run4(1'b1, 1'b0, 32'h7, w, lat, rdat);
      total++;
      if (lat !== 2 || rdat !== '0) begin
         bad++;
         $display("FAIL srst_preload got lat=%0d rdata=%h want lat=2 rdata=0", lat, rdat);
      end
      @(negedge clk);
      ifc4.mem_req_vld = 1'b1; ifc4.mem_rd_en = 1'b1; ifc4.mem_addr = 32'h7;
      c0 = cyc;
      // cycles c0+2.. are S_RD_WAIT; pulse soft reset in the second of them
      while (cyc < c0 + 3) @(negedge clk);
      soft_rst4 = 1'b1;
      ifc4.mem_req_vld = 1'b0; ifc4.mem_rd_en = 1'b0; ifc4.mem_addr = '0;
      @(negedge clk);
      soft_rst4 = 1'b0;
      total++;
      if ({ifc4.mem_ack_vld, ifc4.mem_err, ifc4.mem_rd_data, ifc4.sram_cs, ifc4.sram_we,
           ifc4.sram_addr, ifc4.sram_wdata} !== '0) begin
         bad++;
         $display("FAIL srst_outputs got ack=%b err=%b rdata=%h cs=%b want all 0",
                  ifc4.mem_ack_vld, ifc4.mem_err, ifc4.mem_rd_data, ifc4.sram_cs);
      end
      saw_ack = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ifc4.mem_ack_vld !== 1'b0) saw_ack = 1'b1;
      end
      total++;
      if (saw_ack !== 1'b0) begin
         bad++;
         $display("FAIL srst_no_ack got ack after soft reset want none");
      end
      run4(1'b0, 1'b1, 32'h7, '0, lat, rdat);
      total++;
      if (lat !== 6 || rdat !== w) begin
         bad++;
         $display("FAIL srst_next_read got lat=%0d rdata=%h want lat=6 rdata=%h", lat, rdat, w);
      end
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_write();
      test_read();
      test_illegal_addr();
      test_illegal_both();
      test_back_to_back();
      test_soft_rst();
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
